// File: rtl/operand_alignment_if.sv
// Handshake and data bundle between the FP-add operand source, the alignment stage,
// and the normalization stage that consumes its results.
interface operand_alignment_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_sub;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  big_exponent;
   logic [13:0] mant_big;
   logic [13:0] mant_small;
   logic        final_operation;
   logic        result_sign;
   logic        zero_flag;
   logic        special_flag;

   modport master (
      output in_valid, op_a, op_b, op_sub, out_ready,
      input  in_ready, out_valid, big_exponent, mant_big, mant_small,
             final_operation, result_sign, zero_flag, special_flag
   );

   modport slave (
      input  in_valid, op_a, op_b, op_sub, out_ready,
      output in_ready, out_valid, big_exponent, mant_big, mant_small,
             final_operation, result_sign, zero_flag, special_flag
   );
endinterface

// File: rtl/operand_alignment_block.sv
// Binary16 adder front end: unpacks and orders two operands by magnitude, then
// right-aligns the smaller significand SHIFT_STEP bits per cycle with sticky collection.
module operand_alignment_block #(
   parameter int SHIFT_STEP = 1,
   parameter int MAX_SHIFT  = 14
) (
   input logic clk,
   input logic rst,
   operand_alignment_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

   state_t      state_q;
   logic [4:0]  big_exp_q;
   logic [13:0] mant_big_q;
   logic [13:0] mant_small_q;
   logic        fop_q;
   logic        sign_q;
   logic        special_q;
   logic [3:0]  rem_q;

   logic [4:0]  exp_a, exp_b, eff_a, eff_b, diff;
   logic [13:0] sig_a, sig_b;
   logic        a_big, sign_b_eff, special_d;
   logic [3:0]  shift_d;

   always_comb begin
      exp_a      = bus.op_a[14:10];
      exp_b      = bus.op_b[14:10];
      eff_a      = (exp_a == 5'd0) ? 5'd1 : exp_a;
      eff_b      = (exp_b == 5'd0) ? 5'd1 : exp_b;
      sig_a      = {exp_a != 5'd0, bus.op_a[9:0], 3'b000};
      sig_b      = {exp_b != 5'd0, bus.op_b[9:0], 3'b000};
      // Ties go to A so that equal magnitudes always order the same way.
      a_big      = {eff_a, bus.op_a[9:0]} >= {eff_b, bus.op_b[9:0]};
      sign_b_eff = bus.op_b[15] ^ bus.op_sub;
      diff       = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
      shift_d    = (diff > 5'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : diff[3:0];
      special_d  = (&exp_a) | (&exp_b);
   end

   logic [3:0]  k;
   logic [13:0] mask, shifted, mant_small_d;
   logic [3:0]  rem_d;

   always_comb begin
      k            = (rem_q > 4'(SHIFT_STEP)) ? 4'(SHIFT_STEP) : rem_q;
      mask         = (14'd1 << k) - 14'd1;
      shifted      = mant_small_q >> k;
      // Everything that falls off the right, old LSB included, folds into the sticky bit.
      mant_small_d = {shifted[13:1], shifted[0] | (|(mant_small_q & mask))};
      rem_d        = rem_q - k;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         big_exp_q    <= '0;
         mant_big_q   <= '0;
         mant_small_q <= '0;
         fop_q        <= 1'b0;
         sign_q       <= 1'b0;
         special_q    <= 1'b0;
         rem_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  big_exp_q    <= a_big ? eff_a : eff_b;
                  mant_big_q   <= a_big ? sig_a : sig_b;
                  mant_small_q <= a_big ? sig_b : sig_a;
                  fop_q        <= bus.op_a[15] ^ sign_b_eff;
                  sign_q       <= a_big ? bus.op_a[15] : sign_b_eff;
                  special_q    <= special_d;
                  rem_q        <= shift_d;
                  state_q      <= (shift_d == 4'd0 || special_d) ? DONE : ALIGN;
               end
            end
            ALIGN: begin
               mant_small_q <= mant_small_d;
               rem_q        <= rem_d;
               if (rem_d == 4'd0) state_q <= DONE;
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready        = (state_q == IDLE);
   assign bus.out_valid       = (state_q == DONE);
   assign bus.big_exponent    = big_exp_q;
   assign bus.mant_big        = mant_big_q;
   assign bus.mant_small      = mant_small_q;
   assign bus.final_operation = fop_q;
   assign bus.result_sign     = sign_q;
   assign bus.special_flag    = special_q;
   // Qualified by DONE so the flag reads 0 out of reset and between results.
   assign bus.zero_flag       = (state_q == DONE) && (mant_small_q == 14'd0);

endmodule

// File: tb/tb_operand_alignment_block.sv
// Directed bench for operand_alignment_block (SHIFT_STEP = 1): hand-computed
// alignment results, latencies, output hold, and reset abort.
module tb_operand_alignment_block;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   operand_alignment_if bus();

   operand_alignment_block #(.SHIFT_STEP(1), .MAX_SHIFT(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_sub   = sub;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op_a     = 16'hFFFF;
      bus.op_b     = 16'hFFFF;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic expect_out(input string tag, input logic [4:0] be, input logic [13:0] mb,
                             input logic [13:0] ms, input logic fop, input logic rs,
                             input logic zf, input logic sf);
      check({tag, "_vld"},  32'(bus.out_valid), 32'd1);
      check({tag, "_rdy"},  32'(bus.in_ready), 32'd0);
      check({tag, "_bexp"}, 32'(bus.big_exponent), 32'(be));
      check({tag, "_mbig"}, 32'(bus.mant_big), 32'(mb));
      check({tag, "_msml"}, 32'(bus.mant_small), 32'(ms));
      check({tag, "_fop"},  32'(bus.final_operation), 32'(fop));
      check({tag, "_sign"}, 32'(bus.result_sign), 32'(rs));
      check({tag, "_zero"}, 32'(bus.zero_flag), 32'(zf));
      check({tag, "_spec"}, 32'(bus.special_flag), 32'(sf));
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_back_rdy"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_back_vld"}, 32'(bus.out_valid), 32'd0);
   endtask

   int lat;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = 16'h0;
      bus.op_b      = 16'h0;
      bus.op_sub    = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_rdy",  32'(bus.in_ready), 32'd1);
      check("rst_vld",  32'(bus.out_valid), 32'd0);
      check("rst_bexp", 32'(bus.big_exponent), 32'd0);
      check("rst_mbig", 32'(bus.mant_big), 32'd0);
      check("rst_msml", 32'(bus.mant_small), 32'd0);
      check("rst_spec", 32'(bus.special_flag), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1.0 + 1.0: equal magnitudes, no shift
      issue(16'h3C00, 16'h3C00, 1'b0, lat);
      check("t1_lat", 32'(lat), 32'd1);
      expect_out("t1", 5'd15, 14'h2000, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
      release_out("t1");

      // 0.5 + -1.0: B is larger, one-bit shift, effective subtract
      issue(16'h3800, 16'hBC00, 1'b0, lat);
      check("t2_lat", 32'(lat), 32'd2);
      expect_out("t2", 5'd15, 14'h2000, 14'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
      release_out("t2");

      // 1.0 + smallest denormal: clamped shift of 14, only sticky survives
      issue(16'h3C00, 16'h0001, 1'b0, lat);
      check("t3_lat", 32'(lat), 32'd15);
      expect_out("t3", 5'd15, 14'h2000, 14'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      release_out("t3");

      // 1.0 + 0.0: aligned significand is zero
      issue(16'h3C00, 16'h0000, 1'b0, lat);
      check("t4_lat", 32'(lat), 32'd15);
      expect_out("t4", 5'd15, 14'h2000, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      release_out("t4");

      // 1.0 - 1.0 via op_sub: subtract flips B's sign, tie keeps A big
      issue(16'h3C00, 16'h3C00, 1'b1, lat);
      check("t5_lat", 32'(lat), 32'd1);
      expect_out("t5", 5'd15, 14'h2000, 14'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
      release_out("t5");

      // +Inf + 1.0: special passes through unshifted, then hold with out_ready low
      issue(16'h7C00, 16'h3C00, 1'b0, lat);
      check("t6_lat", 32'(lat), 32'd1);
      expect_out("t6", 5'd31, 14'h2000, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         expect_out("t6_hold", 5'd31, 14'h2000, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      release_out("t6");

      // Abort in the 5th ALIGN cycle of a 14-step alignment
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = 16'h3C00;
      bus.op_b     = 16'h0001;
      bus.op_sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("t7_pre_vld", 32'(bus.out_valid), 32'd0);
      check("t7_pre_rdy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("t7_vld",  32'(bus.out_valid), 32'd0);
      check("t7_rdy",  32'(bus.in_ready), 32'd1);
      check("t7_bexp", 32'(bus.big_exponent), 32'd0);
      check("t7_mbig", 32'(bus.mant_big), 32'd0);
      check("t7_msml", 32'(bus.mant_small), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(16'h3800, 16'hBC00, 1'b0, lat);
      check("t8_lat", 32'(lat), 32'd2);
      expect_out("t8", 5'd15, 14'h2000, 14'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
      release_out("t8");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
